// File: rtl/dft_probe_pkg.sv
// Shared types and defaults for the DFT probe blocks (observe and inject sides).
package dft_probe_pkg;

    // Observe-probe sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } dftobs_state_t;

    // Default synchronizer depth for probe inputs crossing into the DFT clock domain.
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/dft_sync_vec.sv
// Multi-flop vector synchronizer with asynchronous reset. Each bit is synchronized
// independently; bits of a changing vector may land on different cycles.
module dft_sync_vec #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg_q [STAGES];

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/dftprobe_observe_shift.sv
// Observe-side DFT probe: captures synchronized internal nets and shifts them out on tdo,
// LSB first, while tdi fills in from the upstream instance of the chain.
module dftprobe_observe_shift
    import dft_probe_pkg::*;
#(
    parameter int unsigned NPROBE      = 8,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ten,
    input  logic              cap,
    input  logic              shift,
    input  logic              tdi,
    input  logic [NPROBE-1:0] probe,
    output logic              tdo,
    output logic              busy,
    output logic              done,
    input  logic              CELG,
    input  logic              CELSUB,
    input  logic              CELV
);

    localparam int unsigned CNTW = $clog2(NPROBE + 1);

    dftobs_state_t     state_q, state_d;
    logic [NPROBE-1:0] sreg_q, sreg_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [NPROBE-1:0] psync;

    // Supply pins exist only for netlist/LVS consistency with the tdi-side cells.
    logic unused_supply;
    assign unused_supply = CELG ^ CELSUB ^ CELV;

    dft_sync_vec #(
        .WIDTH  (NPROBE),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (probe),
        .q   (psync)
    );

    // Next-state logic: capture once, then shift NPROBE bits with optional pauses.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (!ten) begin
            // Dropping test enable aborts without a done pulse and wipes the chain data.
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // shift is ignored here, so cap always wins over a coincident shift.
                    if (cap) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    sreg_d  = psync;
                    cnt_d   = CNTW'(NPROBE);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (shift) begin
                        sreg_d = {tdi, sreg_q[NPROBE-1:1]};
                        cnt_d  = cnt_q - 1'b1;
                        if (cnt_q == CNTW'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // tdo presents the next outgoing bit before its shift edge.
    assign tdo  = ten & sreg_q[0];
    assign busy = (state_q == CAPTURE) || (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_dftprobe_observe_shift.sv
// Scoreboard bench: stimulus pushes expected tdo bits; a negedge monitor pops and compares
// whenever the downstream instance performs a shift. Two instances are daisy-chained.
module tb_dftprobe_observe_shift;

    logic       clk = 1'b0;
    logic       rst, ten, cap_dn, cap_up, shift, tdi;
    logic [7:0] probe_dn, probe_up;
    logic       tdo_dn, busy_dn, done_dn;
    logic       tdo_up, busy_up, done_up;

    typedef struct {
        logic dn;
        logic up;
        logic chk_up;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total     = 0;
    int   bad       = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    always #5 clk = ~clk;

    dftprobe_observe_shift #(.NPROBE(8), .SYNC_STAGES(2)) u_up (
        .clk (clk), .rst (rst), .ten (ten), .cap (cap_up), .shift (shift), .tdi (tdi),
        .probe (probe_up), .tdo (tdo_up), .busy (busy_up), .done (done_up),
        .CELG (1'b0), .CELSUB (1'b0), .CELV (1'b1)
    );

    dftprobe_observe_shift #(.NPROBE(8), .SYNC_STAGES(2)) u_dn (
        .clk (clk), .rst (rst), .ten (ten), .cap (cap_dn), .shift (shift), .tdi (tdo_up),
        .probe (probe_dn), .tdo (tdo_dn), .busy (busy_dn), .done (done_dn),
        .CELG (1'b0), .CELSUB (1'b0), .CELV (1'b1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle cap; returns with the instance(s) in SHIFT and probe[0] on tdo.
    task automatic capture(input bit both);
        cap_dn = 1'b1;
        cap_up = both;
        cyc();
        cap_dn = 1'b0;
        cap_up = 1'b0;
        cyc();
    endtask

    task automatic shift_bits(input logic [7:0] pd, input logic [7:0] pu, input bit chk_up,
                              input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            q.push_back('{dn: pd[i], up: pu[i], chk_up: chk_up});
            shift = 1'b1;
            cyc();
            if (gaps && i < n - 1) begin
                shift = 1'b0;
                check("gap_busy", busy_dn, 8'd1);
                check("gap_done", done_dn, 8'd0);
                cyc();
            end
        end
        shift = 1'b0;
    endtask

    task automatic finish_check(input string name);
        check({name, "_done"}, done_dn, 8'd1);
        check({name, "_busy"}, busy_dn, 8'd0);
        done_exp++;
        cyc();
        check({name, "_done_gone"}, done_dn, 8'd0);
    endtask

    // Monitor: every active shift cycle of the downstream instance must match the scoreboard.
    always @(negedge clk) begin
        if (done_dn) done_seen++;
        if (!rst && ten && shift && busy_dn) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_shift: got tdo=%0b expected no shift at %0t",
                         tdo_dn, $time);
            end else begin
                mon_e = q.pop_front();
                check("tdo_dn", {7'd0, tdo_dn}, {7'd0, mon_e.dn});
                if (mon_e.chk_up) check("tdo_up", {7'd0, tdo_up}, {7'd0, mon_e.up});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ten = 1'b0; cap_dn = 1'b0; cap_up = 1'b0; shift = 1'b0; tdi = 1'b0;
        probe_dn = 8'h00; probe_up = 8'h00;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("rst_tdo", tdo_dn, 8'd0);
        check("rst_busy", busy_dn, 8'd0);
        check("rst_done", done_dn, 8'd0);
        ten = 1'b1;

        // Basic capture and shift-out of A5, tdi=0.
        probe_dn = 8'hA5;
        repeat (4) cyc();
        capture(1'b0);
        check("a5_busy", busy_dn, 8'd1);
        shift_bits(8'hA5, 8'h00, 1'b0, 8, 1'b0);
        finish_check("a5");
        check("a5_sreg_cleared", tdo_dn, 8'd0);

        // Chain: downstream emits 81 while upstream emits 3C into it; downstream ends up
        // holding 3C, whose bit 0 shows on tdo once idle.
        probe_dn = 8'h81;
        probe_up = 8'h3C;
        repeat (4) cyc();
        capture(1'b1);
        shift_bits(8'h81, 8'h3C, 1'b1, 8, 1'b0);
        check("chain_up_done", done_up, 8'd1);
        finish_check("chain");
        check("chain_dn_sreg0", tdo_dn, 8'd0);
        check("chain_up_idle", busy_up, 8'd0);

        // Paused shifting: state must hold across shift=0 cycles.
        probe_dn = 8'h96;
        repeat (4) cyc();
        capture(1'b0);
        shift_bits(8'h96, 8'h00, 1'b0, 8, 1'b1);
        finish_check("pause");

        // ten dropped mid-shift: abort, clear, no done; then a clean re-capture.
        probe_dn = 8'hFF;
        repeat (4) cyc();
        capture(1'b0);
        shift_bits(8'hFF, 8'h00, 1'b0, 3, 1'b0);
        check("abort_pre_tdo", tdo_dn, 8'd1);
        ten = 1'b0;
        #1;
        check("abort_gated_tdo", tdo_dn, 8'd0);
        cyc();
        check("abort_busy", busy_dn, 8'd0);
        check("abort_done", done_dn, 8'd0);
        ten = 1'b1;
        #1;
        check("abort_sreg_cleared", tdo_dn, 8'd0);
        cyc();
        check("abort_stays_idle", busy_dn, 8'd0);
        capture(1'b0);
        shift_bits(8'hFF, 8'h00, 1'b0, 8, 1'b0);
        finish_check("recap");

        // Synchronizer latency: edge coincident with cap is too late (00 captured);
        // edge one cycle earlier than that arrives in time (FF captured).
        probe_dn = 8'h00;
        repeat (4) cyc();
        probe_dn = 8'hFF;
        capture(1'b0);
        shift_bits(8'h00, 8'h00, 1'b0, 8, 1'b0);
        finish_check("sync_late");
        probe_dn = 8'h00;
        repeat (4) cyc();
        probe_dn = 8'hFF;
        cyc();
        capture(1'b0);
        shift_bits(8'hFF, 8'h00, 1'b0, 8, 1'b0);
        finish_check("sync_ok");

        // Asynchronous reset mid-shift.
        probe_dn = 8'hA5;
        repeat (4) cyc();
        capture(1'b0);
        shift_bits(8'hA5, 8'h00, 1'b0, 2, 1'b0);
        check("mid_pre_tdo", tdo_dn, 8'd1);
        check("mid_pre_busy", busy_dn, 8'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_tdo", tdo_dn, 8'd0);
        check("mid_rst_busy", busy_dn, 8'd0);
        check("mid_rst_done", done_dn, 8'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_busy", busy_dn, 8'd0);
        check("post_rst_tdo", tdo_dn, 8'd0);

        repeat (2) cyc();
        check("scoreboard_empty", 8'(q.size()), 8'd0);
        check("done_count", 8'(done_seen), 8'(done_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
